// File: rtl/mic3_pkg.sv
// Shared definitions for the mic3 serial ADC reader: FSM state encoding,
// frame geometry, default timing parameters and a counter-width helper.
package mic3_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_t;

  localparam int FRAME_BITS       = 16;
  localparam int DATA_BITS        = 12;
  localparam int LEAD_ZEROS       = 4;
  localparam int DEF_CLK_HALF     = 4;
  localparam int DEF_QUIET_CYCLES = 8;
  localparam int BIT_CNT_W        = $clog2(FRAME_BITS + 1);

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mic3_sclk_gen.sv
// SCLK generator: half-period counter plus registered SCLK level and
// strobes flagging the cycle in which SCLK is about to rise or fall.
module mic3_sclk_gen
  import mic3_pkg::*;
#(
  parameter int CLK_HALF = DEF_CLK_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic allow_fall,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic half_end
);

  localparam int CW = cnt_width(CLK_HALF);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);

  logic [CW-1:0] cnt_reg;
  logic          sclk_reg;

  assign half_end  = run && (cnt_reg == HALF_LAST);
  assign sclk_rise = half_end && !sclk_reg;
  // The final high half of a frame ends without a fall so SCLK idles high.
  assign sclk_fall = half_end && sclk_reg && allow_fall;
  assign sclk      = sclk_reg;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b1;
    end else if (half_end) begin
      cnt_reg <= '0;
      if (sclk_rise) begin
        sclk_reg <= 1'b1;
      end else if (sclk_fall) begin
        sclk_reg <= 1'b0;
      end
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mic3_top.sv
// Serial ADC frame reader: a rising edge on read runs one 16-bit SPI-style
// frame and publishes the low 12 bits on audio with a one-cycle new_data strobe.
module mic3_top
  import mic3_pkg::*;
#(
  parameter int CLK_HALF     = DEF_CLK_HALF,
  parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read,
  input  logic                 MISO,
  output logic                 SCLK,
  output logic                 CS,
  output logic [DATA_BITS-1:0] audio,
  output logic                 new_data
);

  localparam int QW = cnt_width(QUIET_CYCLES);
  localparam logic [QW-1:0]        QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BITS_ALL   = BIT_CNT_W'(FRAME_BITS);

  state_t                 state_reg, state_next;
  logic                   read_reg;
  logic                   armed_reg;
  logic                   cs_reg;
  logic                   new_data_reg;
  logic [DATA_BITS-1:0]   audio_reg;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg;
  logic [QW-1:0]          quiet_cnt_reg;

  logic start;
  logic run;
  logic allow_fall;
  logic sclk_rise;
  logic sclk_fall;
  logic half_end;
  logic lead_unused;

  // armed_reg blocks a read that was already high when reset released.
  assign start      = (state_reg == IDLE) && read && !read_reg && armed_reg;
  assign run        = (state_reg == START) || (state_reg == SHIFT);
  assign allow_fall = (bit_cnt_reg != BITS_ALL);
  assign lead_unused = ^shift_reg[FRAME_BITS-1 -: LEAD_ZEROS];

  mic3_sclk_gen #(
    .CLK_HALF(CLK_HALF)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .allow_fall(allow_fall),
    .sclk      (SCLK),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .half_end  (half_end)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = START;
      START:   if (sclk_fall) state_next = SHIFT;
      SHIFT:   if (half_end && (bit_cnt_reg == BITS_ALL)) state_next = DONE;
      DONE:    state_next = QUIET;
      QUIET:   if (quiet_cnt_reg == QUIET_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      read_reg      <= 1'b0;
      armed_reg     <= 1'b0;
      cs_reg        <= 1'b1;
      new_data_reg  <= 1'b0;
      audio_reg     <= '0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      quiet_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      read_reg  <= read;
      if (!read) begin
        armed_reg <= 1'b1;
      end
      // CS and new_data are decoded from the next state so they stay registered.
      cs_reg       <= !((state_next == START) || (state_next == SHIFT));
      new_data_reg <= (state_next == DONE);
      if (state_next == DONE) begin
        audio_reg <= shift_reg[DATA_BITS-1:0];
      end
      if (start) begin
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
      end else if (sclk_rise && (state_reg == SHIFT)) begin
        shift_reg   <= {shift_reg[FRAME_BITS-2:0], MISO};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      if (state_reg == QUIET) begin
        quiet_cnt_reg <= quiet_cnt_reg + 1'b1;
      end else begin
        quiet_cnt_reg <= '0;
      end
    end
  end

  assign CS       = cs_reg;
  assign new_data = new_data_reg;
  assign audio    = audio_reg;

endmodule

// File: tb/tb_mic3_top.sv
// Self-checking bench for mic3_top: an ADC model serves 16-bit words on falling
// SCLK, and frame-level expectations come from the frame format rules.
module tb_mic3_top;

  localparam int CLK_HALF     = 4;
  localparam int QUIET_CYCLES = 8;
  localparam int CS_LOW_EXP   = CLK_HALF + 32 * CLK_HALF;
  localparam int FRAME_WAIT   = 1 + CS_LOW_EXP + 1 + QUIET_CYCLES + 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        MISO = 1'b0;
  logic        SCLK;
  logic        CS;
  logic [11:0] audio;
  logic        new_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor counters, cleared by the stimulus between transactions.
  int cs_falls = 0, cs_low = 0, sclk_rises = 0, sclk_toggles = 0, nd_cycles = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_nd = 1'b0;
  logic [11:0] prev_audio = 12'h000, audio_before = 12'h000;

  logic [15:0] adc_word = 16'h0000;
  int          bit_idx = 15;
  logic [11:0] model_audio = 12'h000;

  mic3_top #(
    .CLK_HALF    (CLK_HALF),
    .QUIET_CYCLES(QUIET_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .MISO    (MISO),
    .SCLK    (SCLK),
    .CS      (CS),
    .audio   (audio),
    .new_data(new_data)
  );

  always #5 clk = ~clk;

  // ADC: next bit of the word appears on each falling SCLK, MSB first.
  always @(negedge CS) bit_idx = 15;
  always @(negedge SCLK) begin
    if (!CS && bit_idx >= 0) begin
      MISO = adc_word[bit_idx];
      bit_idx = bit_idx - 1;
    end
  end

  always @(negedge clk) begin
    if (prev_cs && !CS) cs_falls = cs_falls + 1;
    if (!CS) cs_low = cs_low + 1;
    if (!prev_sclk && SCLK) sclk_rises = sclk_rises + 1;
    if (prev_sclk != SCLK) sclk_toggles = sclk_toggles + 1;
    if (new_data) nd_cycles = nd_cycles + 1;
    if (new_data && !prev_nd) audio_before = prev_audio;
    prev_cs    = CS;
    prev_sclk  = SCLK;
    prev_nd    = new_data;
    prev_audio = audio;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1;
    cs_falls = 0; cs_low = 0; sclk_rises = 0; sclk_toggles = 0; nd_cycles = 0;
  endtask

  // One transaction: read high for 'hold' cycles, optional 2-cycle re-pulse
  // at cycle 'repulse', then frame-level checks against the word's low 12 bits.
  task automatic run_frame(input string name, input logic [15:0] word,
                           input int hold, input int repulse);
    int total;
    logic [11:0] prev_model;
    adc_word   = word;
    prev_model = model_audio;
    clear_mon();
    total = ((hold > FRAME_WAIT) ? hold : FRAME_WAIT) + 10;
    for (int c = 0; c < total; c++) begin
      read = (c < hold) || (repulse > 0 && c >= repulse && c < repulse + 2);
      @(posedge clk); #1;
    end
    read = 1'b0;
    model_audio = word[11:0];
    @(negedge clk);
    $display("frame %s word=%04h audio=%03h cs_falls=%0d rises=%0d cs_low=%0d nd=%0d",
             name, word, audio, cs_falls, sclk_rises, cs_low, nd_cycles);
    check({name, " cs_falls"}, cs_falls, 1);
    check({name, " sclk_rises"}, sclk_rises, 16);
    check({name, " cs_low"}, cs_low, CS_LOW_EXP);
    check({name, " new_data_cycles"}, nd_cycles, 1);
    check({name, " audio"}, {20'h0, audio}, {20'h0, model_audio});
    check({name, " audio_before"}, {20'h0, audio_before}, {20'h0, prev_model});
  endtask

  initial begin
    int guard;
    // Reset and idle behaviour.
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst CS", CS, 1);
    check("rst SCLK", SCLK, 1);
    check("rst audio", audio, 0);
    check("rst new_data", new_data, 0);
    clear_mon();
    repeat (100) @(posedge clk);
    @(negedge clk);
    $display("idle toggles=%0d cs_falls=%0d", sclk_toggles, cs_falls);
    check("idle sclk_toggles", sclk_toggles, 0);
    check("idle cs_falls", cs_falls, 0);

    run_frame("cde", 16'h0CDE, 2, 0);
    repeat (20) @(posedge clk);
    run_frame("123", 16'h0123, 2, 0);
    run_frame("fff", 16'hFFFF, 2, 0);
    run_frame("000", 16'h0000, 2, 0);
    for (int i = 0; i < 4; i++) run_frame("rand", 16'($urandom), 1 + $urandom_range(0, 3), 0);
    run_frame("repulse", 16'($urandom), 2, 50);
    run_frame("hold500", 16'h0A5C, 500, 0);

    // Reset during SCLK period 8 aborts the frame.
    adc_word = 16'h0ABC;
    clear_mon();
    read = 1'b1;
    repeat (2) @(posedge clk);
    #1 read = 1'b0;
    guard = 0;
    while (sclk_rises < 8 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("midrst reached_period8", (guard < 300), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_audio = 12'h000;
    @(negedge clk);
    check("midrst CS", CS, 1);
    check("midrst SCLK", SCLK, 1);
    check("midrst audio", audio, 0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    $display("midrst nd=%0d audio=%03h", nd_cycles, audio);
    check("midrst new_data_cycles", nd_cycles, 0);
    check("midrst audio_after", audio, 0);
    run_frame("post_rst", 16'h0321, 2, 0);

    // read held high across reset must not start a frame.
    read = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_audio = 12'h000;
    clear_mon();
    repeat (50) @(posedge clk);
    #1 read = 1'b0;
    @(negedge clk);
    $display("held_rst cs_falls=%0d", cs_falls);
    check("held_rst cs_falls", cs_falls, 0);
    repeat (3) @(posedge clk);
    run_frame("after_held", 16'h0777, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mic3_top.md
MIC3_TOP -- requirements
Module: mic3_top

Interface
REQ-001 The block SHALL have parameter CLK_HALF, default 4, meaning clk cycles per SCLK half-period (SCLK = clk/8 = 12.5 MHz at 100 MHz).
REQ-002 The block SHALL have parameter QUIET_CYCLES, default 8, meaning the minimum number of clk cycles CS stays high between frames.
REQ-003 Port clk, input, 1 bit: single system clock, 100 MHz nominal, all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port read, input, 1 bit: conversion request; its rising edge starts one frame.
REQ-006 Port MISO, input, 1 bit: serial data from the ADC.
REQ-007 Port SCLK, output, 1 bit: serial clock to the ADC; idles high.
REQ-008 Port CS, output, 1 bit: active-low chip select.
REQ-009 Port audio, output, 12 bits: last completed sample, unsigned.
REQ-010 Port new_data, output, 1 bit: one-cycle strobe marking an audio update.

Function
REQ-011 The FSM SHALL use these states: IDLE, START, SHIFT, DONE, QUIET.
REQ-012 read SHALL be registered, and a start SHALL require read=1 with registered read=0 while in IDLE.
REQ-013 A rising edge of read outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-014 Holding read high SHALL produce exactly one frame.
REQ-015 IDLE SHALL drive CS=1 and SCLK=1; on a start, CS SHALL go low in the next cycle (enter START).
REQ-016 In START, SCLK SHALL stay high for CLK_HALF cycles, then the FSM SHALL enter SHIFT.
REQ-017 SHIFT SHALL generate exactly 16 SCLK periods, each low for CLK_HALF cycles, then high for CLK_HALF cycles.
REQ-018 MISO SHALL be sampled on the clk cycle in which SCLK rises (ADC data changes on the falling edge).
REQ-019 Samples SHALL shift MSB-first into a 16-bit register.
REQ-020 Frame format: bits 15..12 are leading zeros and SHALL be discarded; bits 11..0 SHALL become audio[11:0].
REQ-021 After the 16th rising SCLK, the FSM SHALL enter DONE with CS=1.
REQ-022 In DONE, audio SHALL load the captured 12 bits and new_data SHALL be 1 for exactly that cycle.
REQ-023 audio SHALL hold its value until the next DONE.
REQ-024 QUIET SHALL keep CS=1 and SCLK=1 for QUIET_CYCLES cycles, then return to IDLE.
REQ-025 CS SHALL be low for CLK_HALF + 32*CLK_HALF = 132 cycles at defaults.
REQ-026 Start-to-start minimum period SHALL be 1 + 132 + 1 + QUIET_CYCLES cycles.
REQ-027 SCLK and CS SHALL be driven directly from registers (glitch-free).
REQ-028 Nonzero leading bits SHALL be ignored without error.

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL enter IDLE with CS=1, SCLK=1, audio=12'h000, new_data=0, shift register=0, counters=0, and registered read=0.
REQ-030 Reset mid-frame SHALL abort the frame, leave audio unchanged at 0, and assert no new_data.
REQ-031 After reset, a read held high from before reset SHALL NOT start a frame until it falls and rises again.

Structure
REQ-032 Shared package mic3_pkg SHALL hold: the state encoding (IDLE..QUIET), FRAME_BITS=16, DATA_BITS=12, LEAD_ZEROS=4, and default CLK_HALF and QUIET_CYCLES.
REQ-033 Sub-module mic3_sclk_gen SHALL provide the half-period counter and sclk_rise/sclk_fall strobes.
REQ-034 The FSM, shift register and output registers SHALL reside in mic3_top.

Verification
REQ-035 Reset: rst high for 5 cycles -> CS=1, SCLK=1, audio=000, new_data=0; 100 idle cycles -> no SCLK toggles.
REQ-036 ADC model drives 0x0CDE on falling SCLK, read pulse of 2 cycles -> exactly 16 SCLK periods, CS low 132 cycles, one new_data pulse, audio=CDE.
REQ-037 Second frame of 0x0123 after 200 ns idle -> audio=123; new_data high exactly one cycle; audio stays CDE until that cycle.
REQ-038 Read re-pulsed mid-frame, and read held high for 500 cycles -> exactly one frame each; no extra CS fall.
REQ-039 Frame 0xFFFF (leading ones) -> audio=FFF; frame 0x0000 -> audio=000.
REQ-040 rst asserted at SCLK period 8 -> CS=1 next cycle, no new_data, audio=000; next read -> normal frame.
